// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the exec_sequencer control slice: opcodes, FSM states,
// the HALT encoding and the instruction field positions.
package exec_sequencer_pkg;

  localparam int PC_W_DEF = 8;
  localparam int INSTR_W  = 9;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  // instruction field slices: [8:6] opcode, [5:3] ra, [2:0] rb / lut index
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RA_MSB = 5;
  localparam int RA_LSB = 3;
  localparam int RB_MSB = 2;
  localparam int RB_LSB = 0;

  // ALU opcodes, shared with the ALU
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_XOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_RSL  = 3'd3,
    OP_MOV  = 3'd4,
    OP_LD   = 3'd5,
    OP_ST   = 3'd6,
    OP_BLQZ = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4,
    S_MEMWB  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Datapath-facing bundle of the sequencer: start/done handshake, ROM port,
// ALU opcode/flag, register-file addressing and data-memory strobes.
interface exec_sequencer_if #(parameter int PC_W = 8);

  logic            start;
  logic            busy;
  logic            done;
  logic [8:0]      instr;
  logic            jumpFlag;
  logic [PC_W-1:0] branchTarget;
  logic [PC_W-1:0] instrAddr;
  logic [2:0]      aluOp;
  logic [2:0]      regAddrA;
  logic [2:0]      regAddrB;
  logic            regWrEn;
  logic [2:0]      regWrAddr;
  logic            wbSel;
  logic            memRdEn;
  logic            memWrEn;
  logic [2:0]      lutIdx;

  modport master (
    input  start, instr, jumpFlag, branchTarget,
    output busy, done, instrAddr, aluOp, regAddrA, regAddrB,
           regWrEn, regWrAddr, wbSel, memRdEn, memWrEn, lutIdx
  );

  modport slave (
    output start, instr, jumpFlag, branchTarget,
    input  busy, done, instrAddr, aluOp, regAddrA, regAddrB,
           regWrEn, regWrAddr, wbSel, memRdEn, memWrEn, lutIdx
  );

endinterface

// File: rtl/exec_sequencer_decode.sv
// Combinational instruction decode: register addresses, branch LUT index and
// instruction class flags. BLQZ compares against r0, so its B port reads r0.
module exec_sequencer_decode
  import exec_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output opcode_t            opcode,
  output logic [2:0]         reg_a,
  output logic [2:0]         reg_b,
  output logic [2:0]         lut_idx,
  output logic               is_write,
  output logic               is_load,
  output logic               is_store,
  output logic               is_branch,
  output logic               is_halt
);

  // split the instruction into fields and classify it
  always_comb begin
    opcode    = opcode_t'(instr[OP_MSB:OP_LSB]);
    is_halt   = (instr == HALT_INSTR);
    is_branch = (opcode == OP_BLQZ) && !is_halt;
    is_load   = (opcode == OP_LD);
    is_store  = (opcode == OP_ST);
    is_write  = opcode inside {OP_ADD, OP_XOR, OP_AND, OP_RSL, OP_MOV};
    reg_a     = instr[RA_MSB:RA_LSB];
    reg_b     = is_branch ? 3'd0 : instr[RB_MSB:RB_LSB];
    lut_idx   = is_branch ? instr[RB_MSB:RB_LSB] : 3'd0;
  end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the 9-bit-instruction core.
// Owns the pc, decodes each instruction and sequences ALU, register file and
// data memory through FETCH/DECODE/EXEC/RESULT(/MEMWB).
// Optional build macro EXEC_PERF_COUNT_EN adds saturating cycleCount and
// instrCount outputs.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | pc on instrAddr, ROM read in flight
// DECODE | ROM data valid; latch decode, drive register addresses
// EXEC   | aluOp driven
// RESULT | commit: write strobe / memory strobe / pc update
// MEMWB  | load write-back from memory read data
// HALT   | 9'h1FF decoded; done high, start restarts at pc 0
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  exec_sequencer_if.master bus
`ifdef EXEC_PERF_COUNT_EN
  ,
  output logic [15:0] cycleCount,
  output logic [15:0] instrCount
`endif
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [2:0]      alu_op;
  logic [2:0]      reg_a;
  logic [2:0]      reg_b;
  logic [2:0]      wr_addr;
  logic [2:0]      lut_idx;
  logic            reg_wr;
  logic            wb_sel;
  logic            mem_rd;
  logic            mem_wr;
  logic            busy;
  logic            done;
  logic            cur_write;
  logic            cur_load;
  logic            cur_store;
  logic            cur_branch;

  opcode_t    d_opcode;
  logic [2:0] d_reg_a;
  logic [2:0] d_reg_b;
  logic [2:0] d_lut_idx;
  logic       d_write;
  logic       d_load;
  logic       d_store;
  logic       d_branch;
  logic       d_halt;

  exec_sequencer_decode u_decode (
    .instr     (bus.instr),
    .opcode    (d_opcode),
    .reg_a     (d_reg_a),
    .reg_b     (d_reg_b),
    .lut_idx   (d_lut_idx),
    .is_write  (d_write),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_branch (d_branch),
    .is_halt   (d_halt)
  );

  // sequencing FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      alu_op     <= 3'd0;
      reg_a      <= 3'd0;
      reg_b      <= 3'd0;
      wr_addr    <= 3'd0;
      lut_idx    <= 3'd0;
      reg_wr     <= 1'b0;
      wb_sel     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_write  <= 1'b0;
      cur_load   <= 1'b0;
      cur_store  <= 1'b0;
      cur_branch <= 1'b0;
    end else begin
      // strobes and aluOp are single-cycle unless re-asserted below
      alu_op <= 3'd0;
      reg_wr <= 1'b0;
      wb_sel <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state <= S_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (d_halt) begin
            state <= S_HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= S_EXEC;
            alu_op     <= d_opcode;
            reg_a      <= d_reg_a;
            reg_b      <= d_reg_b;
            wr_addr    <= d_reg_a;
            lut_idx    <= d_lut_idx;
            cur_write  <= d_write;
            cur_load   <= d_load;
            cur_store  <= d_store;
            cur_branch <= d_branch;
          end
        end
        S_EXEC: begin
          state  <= S_RESULT;
          reg_wr <= cur_write;
          mem_rd <= cur_load;
          mem_wr <= cur_store;
        end
        S_RESULT: begin
          if (cur_load) begin
            state  <= S_MEMWB;
            reg_wr <= 1'b1;
            wb_sel <= 1'b1;
          end else begin
            state <= S_FETCH;
            // jumpFlag is the ALU's registered compare from EXEC
            pc    <= (cur_branch && bus.jumpFlag) ? bus.branchTarget : pc + 1'b1;
          end
        end
        S_MEMWB: begin
          state <= S_FETCH;
          pc    <= pc + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instrAddr = pc;
  assign bus.aluOp     = alu_op;
  assign bus.regAddrA  = reg_a;
  assign bus.regAddrB  = reg_b;
  assign bus.regWrEn   = reg_wr;
  assign bus.regWrAddr = wr_addr;
  assign bus.wbSel     = wb_sel;
  assign bus.memRdEn   = mem_rd;
  assign bus.memWrEn   = mem_wr;
  assign bus.lutIdx    = lut_idx;
  assign bus.busy      = busy;
  assign bus.done      = done;

`ifdef EXEC_PERF_COUNT_EN
  logic commit;
  assign commit = ((state == S_RESULT) && !cur_load) || (state == S_MEMWB);

  // saturating busy-cycle and committed-instruction counters, cleared on start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycleCount <= 16'd0;
      instrCount <= 16'd0;
    end else if (((state == S_IDLE) || (state == S_HALT)) && bus.start) begin
      cycleCount <= 16'd0;
      instrCount <= 16'd0;
    end else begin
      if (busy && (cycleCount != 16'hFFFF)) cycleCount <= cycleCount + 16'd1;
      if (commit && (instrCount != 16'hFFFF)) instrCount <= instrCount + 16'd1;
    end
  end
`endif

endmodule
